// File: rtl/fetch_pkg.sv
// Purpose : shared constants and types for the instruction fetch stage.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    // Fetch FSM states: issue a bus read, wait for its data, hold a valid word.
    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Byte distance between sequential instruction words.
    localparam int PC_INCR = 4;

endpackage

// File: rtl/fetch.sv
// Purpose : instruction fetch stage, one bus read outstanding, feeds decode.
// Latency : zero-wait bus gives one word every 2 cycles (issue+return, then valid).
// Backpressure: ds_stall holds the presented word; i_ibus_rdy low holds the request.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_exec_stall, i_mem_stall     downstream stalls (ORed into ds_stall)
//   i_jump_valid, i_jump_addr     one-cycle redirect from execute, low 2 bits ignored
//   o_ibus_addr, o_ibus_rd        bus read request (address stable until accepted)
//   i_ibus_rdy                    slave accepts the request this cycle
//   i_ibus_rdc, i_ibus_data       read data return, always on a later cycle
//   o_pc, o_instr, o_fetch_stall  word to decode; o_fetch_stall=1 means not valid
module fetch
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_exec_stall,
    input  logic                   i_mem_stall,
    input  logic                   i_jump_valid,
    input  logic [ADDR_WIDTH-1:0]  i_jump_addr,
    output logic [ADDR_WIDTH-1:0]  o_ibus_addr,
    output logic                   o_ibus_rd,
    input  logic                   i_ibus_rdy,
    input  logic                   i_ibus_rdc,
    input  logic [INSTR_WIDTH-1:0] i_ibus_data,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic                   o_fetch_stall
);

    fetch_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  pc_out_q, pc_out_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   discard_q, discard_d;
    // A redirect seen in ISSUE before acceptance is parked here so the
    // in-progress request address stays stable until the slave takes it.
    logic                   jmp_pend_q, jmp_pend_d;
    logic [ADDR_WIDTH-1:0]  jmp_tgt_q, jmp_tgt_d;

    logic                   ds_stall;
    logic [ADDR_WIDTH-1:0]  pc_next;
    logic [ADDR_WIDTH-1:0]  jump_tgt;
    logic                   unused_jump_lsbs;

    assign ds_stall         = i_exec_stall | i_mem_stall;
    assign pc_next          = pc_q + ADDR_WIDTH'(PC_INCR);
    assign jump_tgt         = {i_jump_addr[ADDR_WIDTH-1:2], 2'b00};
    assign unused_jump_lsbs = ^i_jump_addr[1:0];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_out_d      = pc_out_q;
        instr_d       = instr_q;
        discard_d     = discard_q;
        jmp_pend_d    = jmp_pend_q;
        jmp_tgt_d     = jmp_tgt_q;
        o_ibus_rd     = 1'b0;
        o_ibus_addr   = pc_q;
        o_fetch_stall = 1'b1;

        case (state_q)
            ST_ISSUE: begin
                o_ibus_rd   = 1'b1;
                o_ibus_addr = pc_q;
                if (i_ibus_rdy) begin
                    state_d    = ST_WAIT;
                    jmp_pend_d = 1'b0;
                    // The request just accepted is wrong-path if any redirect
                    // arrived during ISSUE; a same-cycle one is the newest.
                    if (i_jump_valid) begin
                        pc_d      = jump_tgt;
                        discard_d = 1'b1;
                    end else if (jmp_pend_q) begin
                        pc_d      = jmp_tgt_q;
                        discard_d = 1'b1;
                    end
                end else if (i_jump_valid) begin
                    jmp_pend_d = 1'b1;
                    jmp_tgt_d  = jump_tgt;
                end
            end

            ST_WAIT: begin
                if (i_ibus_rdc) begin
                    if (discard_q || i_jump_valid) begin
                        // Wrong-path data: drop it and refetch from pc.
                        state_d   = ST_ISSUE;
                        discard_d = 1'b0;
                        if (i_jump_valid) begin
                            pc_d = jump_tgt;
                        end
                    end else begin
                        instr_d  = i_ibus_data;
                        pc_out_d = pc_q;
                        state_d  = ST_VALID;
                    end
                end else if (i_jump_valid) begin
                    discard_d = 1'b1;
                    pc_d      = jump_tgt;
                end
            end

            ST_VALID: begin
                if (i_jump_valid) begin
                    // Presented word is wrong-path; hide it this cycle.
                    pc_d    = jump_tgt;
                    state_d = ST_ISSUE;
                end else begin
                    o_fetch_stall = 1'b0;
                    if (!ds_stall) begin
                        pc_d        = pc_next;
                        o_ibus_rd   = 1'b1;
                        o_ibus_addr = pc_next;
                        state_d     = i_ibus_rdy ? ST_WAIT : ST_ISSUE;
                    end
                end
            end

            default: begin
                state_d = ST_ISSUE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ISSUE;
            pc_q       <= RESET_PC;
            pc_out_q   <= RESET_PC;
            instr_q    <= '0;
            discard_q  <= 1'b0;
            jmp_pend_q <= 1'b0;
            jmp_tgt_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_out_q   <= pc_out_d;
            instr_q    <= instr_d;
            discard_q  <= discard_d;
            jmp_pend_q <= jmp_pend_d;
            jmp_tgt_q  <= jmp_tgt_d;
        end
    end

    assign o_pc    = pc_out_q;
    assign o_instr = instr_q;

endmodule

// File: tb/tb_fetch.sv
// Purpose : self-checking bench for fetch, cycle-by-cycle directed vectors.
// Latency : each vector is one clock; outputs sampled 1ns after the falling edge.
// Backpressure: bus slave behaviour (rdy/rdc/data) is scripted per vector.
module tb_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_exec_stall, i_mem_stall, i_jump_valid;
    logic [31:0] i_jump_addr;
    logic [31:0] o_ibus_addr;
    logic        o_ibus_rd;
    logic        i_ibus_rdy, i_ibus_rdc;
    logic [31:0] i_ibus_data;
    logic [31:0] o_pc, o_instr;
    logic        o_fetch_stall;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch dut (
        .clk           (clk),
        .rst           (rst),
        .i_exec_stall  (i_exec_stall),
        .i_mem_stall   (i_mem_stall),
        .i_jump_valid  (i_jump_valid),
        .i_jump_addr   (i_jump_addr),
        .o_ibus_addr   (o_ibus_addr),
        .o_ibus_rd     (o_ibus_rd),
        .i_ibus_rdy    (i_ibus_rdy),
        .i_ibus_rdc    (i_ibus_rdc),
        .i_ibus_data   (i_ibus_data),
        .o_pc          (o_pc),
        .o_instr       (o_instr),
        .o_fetch_stall (o_fetch_stall)
    );

    typedef struct {
        logic        rst, xs, ms, jv;
        logic [31:0] ja;
        logic        rdy, rdc;
        logic [31:0] dat;
        logic        e_rd;
        logic [31:0] e_addr;   // compared only when e_rd=1
        logic        e_fs;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    function automatic vec_t mk(input logic rst_i, xs, ms, jv, input logic [31:0] ja,
                                input logic rdy, rdc, input logic [31:0] dat,
                                input logic e_rd, input logic [31:0] e_addr,
                                input logic e_fs, input logic [31:0] e_pc, e_instr);
        vec_t v;
        v.rst = rst_i; v.xs = xs; v.ms = ms; v.jv = jv; v.ja = ja;
        v.rdy = rdy; v.rdc = rdc; v.dat = dat;
        v.e_rd = e_rd; v.e_addr = e_addr; v.e_fs = e_fs;
        v.e_pc = e_pc; v.e_instr = e_instr;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // Drive one vector after the falling edge, check, then let the rising edge apply it.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst          = v.rst;
        i_exec_stall = v.xs;
        i_mem_stall  = v.ms;
        i_jump_valid = v.jv;
        i_jump_addr  = v.ja;
        i_ibus_rdy   = v.rdy;
        i_ibus_rdc   = v.rdc;
        i_ibus_data  = v.dat;
        #1;
        chk("ibus_rd", idx, {31'b0, o_ibus_rd}, {31'b0, v.e_rd});
        if (v.e_rd) chk("ibus_addr", idx, o_ibus_addr, v.e_addr);
        chk("fetch_stall", idx, {31'b0, o_fetch_stall}, {31'b0, v.e_fs});
        chk("pc", idx, o_pc, v.e_pc);
        chk("instr", idx, o_instr, v.e_instr);
    endtask

    localparam int NV = 21;
    vec_t tbl [NV];

    initial begin
        rst = 1'b1; i_exec_stall = 0; i_mem_stall = 0; i_jump_valid = 0;
        i_jump_addr = 0; i_ibus_rdy = 0; i_ibus_rdc = 0; i_ibus_data = 0;
        repeat (2) @(posedge clk);

        //            rst xs ms jv ja            rdy rdc dat             rd addr          fs pc            instr
        tbl[0]  = mk(1, 0, 0, 0, 32'h0,        0, 0, 32'h0,           1, 32'h0,        1, 32'h0,        32'h0);         // reset state
        tbl[1]  = mk(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,           1, 32'h0,        1, 32'h0,        32'h0);         // ISSUE accepted
        tbl[2]  = mk(0, 0, 0, 0, 32'h0,        1, 1, 32'h2400_0001,   0, 32'h0,        1, 32'h0,        32'h0);         // WAIT, data back
        tbl[3]  = mk(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,           1, 32'h4,        0, 32'h0,        32'h2400_0001); // VALID, next req 0x4
        tbl[4]  = mk(0, 0, 0, 0, 32'h0,        1, 1, 32'h1111_1111,   0, 32'h0,        1, 32'h0,        32'h2400_0001); // WAIT
        tbl[5]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,           1, 32'h8,        0, 32'h4,        32'h1111_1111); // VALID, rdy low -> ISSUE
        tbl[6]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,           1, 32'h8,        1, 32'h4,        32'h1111_1111); // ISSUE held
        tbl[7]  = mk(0, 0, 0, 0, 32'h0,        0, 1, 32'hDEAD_BEEF,   1, 32'h8,        1, 32'h4,        32'h1111_1111); // spurious rdc ignored
        tbl[8]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,           1, 32'h8,        1, 32'h4,        32'h1111_1111);
        tbl[9]  = mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,           1, 32'h8,        1, 32'h4,        32'h1111_1111);
        tbl[10] = mk(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,           1, 32'h8,        1, 32'h4,        32'h1111_1111); // accepted
        tbl[11] = mk(0, 0, 0, 1, 32'h0000_1003,0, 0, 32'h0,           0, 32'h0,        1, 32'h4,        32'h1111_1111); // jump in WAIT
        tbl[12] = mk(0, 0, 0, 0, 32'h0,        0, 1, 32'h2222_2222,   0, 32'h0,        1, 32'h4,        32'h1111_1111); // discarded data
        tbl[13] = mk(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,           1, 32'h1000,     1, 32'h4,        32'h1111_1111); // refetch target
        tbl[14] = mk(0, 0, 0, 1, 32'h0000_2000,0, 1, 32'h3333_3333,   0, 32'h0,        1, 32'h4,        32'h1111_1111); // jump with rdc
        tbl[15] = mk(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,           1, 32'h2000,     1, 32'h4,        32'h1111_1111); // no VALID, target
        tbl[16] = mk(0, 0, 0, 0, 32'h0,        0, 1, 32'h4444_4444,   0, 32'h0,        1, 32'h4,        32'h1111_1111);
        tbl[17] = mk(0, 1, 0, 1, 32'h0000_3002,1, 0, 32'h0,           0, 32'h0,        1, 32'h2000,     32'h4444_4444); // jump in VALID w/ stall
        tbl[18] = mk(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,           1, 32'h3000,     1, 32'h2000,     32'h4444_4444);
        tbl[19] = mk(0, 0, 0, 0, 32'h0,        0, 1, 32'h5555_5555,   0, 32'h0,        1, 32'h2000,     32'h4444_4444);
        tbl[20] = mk(0, 0, 1, 0, 32'h0,        1, 0, 32'h0,           0, 32'h0,        0, 32'h3000,     32'h5555_5555); // mem stall holds

        for (int i = 0; i < NV; i++) apply(tbl[i], i);

        // Execute stall for 5 cycles in VALID, rdy high throughout: no request.
        for (int i = 0; i < 5; i++)
            apply(mk(0, 1, 0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h3000, 32'h5555_5555), 100 + i);
        apply(mk(0, 0, 0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h3004, 0, 32'h3000, 32'h5555_5555), 105);

        // Reset in WAIT, then a late rdc that must be ignored.
        apply(mk(1, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h3000, 32'h5555_5555), 110);
        apply(mk(0, 0, 0, 0, 32'h0, 0, 1, 32'h6666_6666, 1, 32'h0, 1, 32'h0, 32'h0), 111);
        apply(mk(0, 0, 0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h0, 1, 32'h0, 32'h0), 112);
        apply(mk(0, 0, 0, 0, 32'h0, 0, 1, 32'h7777_7777, 0, 32'h0, 1, 32'h0, 32'h0), 113);

        // Redirect in ISSUE before acceptance: address held, then discard.
        apply(mk(0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h4, 0, 32'h0, 32'h7777_7777), 114);
        apply(mk(0, 0, 0, 1, 32'h5000, 0, 0, 32'h0, 1, 32'h4, 1, 32'h0, 32'h7777_7777), 115);
        apply(mk(0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 32'h4, 1, 32'h0, 32'h7777_7777), 116);
        apply(mk(0, 0, 0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h4, 1, 32'h0, 32'h7777_7777), 117);
        apply(mk(0, 0, 0, 0, 32'h0, 0, 1, 32'h8888_8888, 0, 32'h0, 1, 32'h0, 32'h7777_7777), 118);
        apply(mk(0, 0, 0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h5000, 1, 32'h0, 32'h7777_7777), 119);

        // Two redirects in WAIT: the second target wins.
        apply(mk(0, 0, 0, 1, 32'h6000, 0, 0, 32'h0, 0, 32'h0, 1, 32'h0, 32'h7777_7777), 120);
        apply(mk(0, 0, 0, 1, 32'h7000, 0, 0, 32'h0, 0, 32'h0, 1, 32'h0, 32'h7777_7777), 121);
        apply(mk(0, 0, 0, 0, 32'h0, 0, 1, 32'h8888_0000, 0, 32'h0, 1, 32'h0, 32'h7777_7777), 122);

        // Redirect on the accepting cycle, then PC wrap past 0xFFFF_FFFC.
        apply(mk(0, 0, 0, 1, 32'hFFFF_FFFF, 1, 0, 32'h0, 1, 32'h7000, 1, 32'h0, 32'h7777_7777), 123);
        apply(mk(0, 0, 0, 0, 32'h0, 0, 1, 32'h9999_0000, 0, 32'h0, 1, 32'h0, 32'h7777_7777), 124);
        apply(mk(0, 0, 0, 0, 32'h0, 1, 0, 32'h0, 1, 32'hFFFF_FFFC, 1, 32'h0, 32'h7777_7777), 125);
        apply(mk(0, 0, 0, 0, 32'h0, 0, 1, 32'hABCD_0123, 0, 32'h0, 1, 32'h0, 32'h7777_7777), 126);
        apply(mk(0, 0, 0, 0, 32'h0, 1, 0, 32'h0, 1, 32'h0, 0, 32'hFFFF_FFFC, 32'hABCD_0123), 127);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
